// File: rtl/pet_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pet_loader_pkg
//  Purpose  : Shared types and constants for the PRG-file DMA loader.
//             - state_t       : loader FSM state encoding
//             - PRG_HDR_BYTES : size of the little-endian load-address header
//  Revision : 1.0  initial release
// ============================================================================
package pet_loader_pkg;

    localparam int PRG_HDR_BYTES = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage : pet_loader_pkg
`default_nettype wire

// File: rtl/prg_dma_loader_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Purpose  : Small show-ahead FIFO. The head entry is visible on dout
//             whenever empty is low; pop consumes it.
//  Ports    : clk, reset_n (async active-low)
//             push/din  - write request and data (ignored while full unless
//                         a pop happens in the same cycle)
//             pop       - consume head (ignored while empty)
//             dout      - head entry (show-ahead)
//             empty/full- occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push while full is kept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed when count_q > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/prg_dma_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prg_dma_loader
//  Purpose  : Loads a PRG file from the ioctl byte stream into machine RAM.
//             Strips the 2-byte little-endian load-address header, buffers
//             payload bytes and writes them through a stallable valid/ack
//             DMA port. Reports load/end addresses and error status.
//  Ports    : clk, reset_n           - clock, async active-low reset
//             ioctl_download/index/wr/dout - mist_io download stream
//             dma_addr/dout/we, dma_ack    - RAM write port (held until ack)
//             busy, done                   - status, done is a 1-cycle pulse
//             load_addr, end_addr          - header address, one past last
//             err_overflow, err_short      - sticky per-load error flags
//  Revision : 1.0  initial release
// ============================================================================
module prg_dma_loader
    import pet_loader_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter int         DMA_AW     = 14,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] FILE_INDEX = 8'h41
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [DMA_AW-1:0] dma_addr,
    output logic [7:0]        dma_dout,
    output logic              dma_we,
    input  logic              dma_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] end_addr,
    output logic              err_overflow,
    output logic              err_short
);

    state_t              state_q, state_d;
    logic                dl_prev_q;
    logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
    logic [ADDR_W-1:0]   end_addr_q,  end_addr_d;
    logic [ADDR_W-1:0]   cur_addr_q,  cur_addr_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_short_q,    err_short_d;

    logic                dl_rise;
    logic                dl_fall;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [7:0]          fifo_dout;
    logic [15:0]         hdr_addr;

    assign dl_rise = ioctl_download && !dl_prev_q;
    assign dl_fall = !ioctl_download && dl_prev_q;

    // Payload bytes are only accepted while in DATA; ioctl cannot be stalled.
    assign fifo_push = (state_q == S_DATA) && ioctl_wr;
    assign fifo_pop  = dma_we && dma_ack;

    assign hdr_addr = {ioctl_dout, load_addr_q[7:0]};

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (ioctl_dout),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Show-ahead DMA: the head stays put until acked, so addr/data are
    // stable for the whole stall.
    assign dma_we       = !fifo_empty;
    assign dma_dout     = fifo_empty ? 8'h00 : fifo_dout;
    assign dma_addr     = cur_addr_q[DMA_AW-1:0];
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign load_addr    = load_addr_q;
    assign end_addr     = end_addr_q;
    assign err_overflow = err_overflow_q;
    assign err_short    = err_short_q;

    always_comb begin
        state_d        = state_q;
        load_addr_d    = load_addr_q;
        end_addr_d     = end_addr_q;
        cur_addr_d     = cur_addr_q;
        err_overflow_d = err_overflow_q;
        err_short_d    = err_short_q;

        case (state_q)
            S_IDLE: begin
                if (dl_rise && (ioctl_index == FILE_INDEX)) begin
                    state_d        = S_HDR_LO;
                    load_addr_d    = '0;
                    end_addr_d     = '0;
                    err_overflow_d = 1'b0;
                    err_short_d    = 1'b0;
                end
            end
            S_HDR_LO: begin
                if (dl_fall) begin
                    err_short_d = 1'b1;
                    state_d     = S_DONE;
                end else if (ioctl_wr) begin
                    load_addr_d = ADDR_W'(ioctl_dout);
                    state_d     = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (dl_fall) begin
                    err_short_d = 1'b1;
                    state_d     = S_DONE;
                end else if (ioctl_wr) begin
                    // end_addr starts at the load address so an empty
                    // payload reports end_addr == load_addr.
                    load_addr_d = ADDR_W'(hdr_addr);
                    cur_addr_d  = ADDR_W'(hdr_addr);
                    end_addr_d  = ADDR_W'(hdr_addr);
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (dl_fall) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pops only occur in DATA/DRAIN, so this never collides with the
        // header writes above.
        if (fifo_pop) begin
            cur_addr_d = cur_addr_q + ADDR_W'(1);
            end_addr_d = cur_addr_q + ADDR_W'(1);
        end

        if (fifo_push && fifo_full && !fifo_pop) err_overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            dl_prev_q      <= 1'b0;
            load_addr_q    <= '0;
            end_addr_q     <= '0;
            cur_addr_q     <= '0;
            err_overflow_q <= 1'b0;
            err_short_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dl_prev_q      <= ioctl_download;
            load_addr_q    <= load_addr_d;
            end_addr_q     <= end_addr_d;
            cur_addr_q     <= cur_addr_d;
            err_overflow_q <= err_overflow_d;
            err_short_q    <= err_short_d;
        end
    end

endmodule : prg_dma_loader
`default_nettype wire

// File: doc/prg_dma_loader.md
Name: prg_dma_loader

Overview:
- Parametrised PRG-file loader that replaces the ad-hoc header/offset logic at top level.
- Consumes the mist_io ioctl byte stream and strips the 2-byte little-endian load-address header.
- Buffers payload bytes in a small FIFO and writes them into machine RAM through a valid/ack DMA port that may stall.
- Reports the load address, the end address and error status, so the top level can patch BASIC pointers after a load.

Parameters:
- ADDR_W, 16: width of load/current/end address counters.
- DMA_AW, 14: width of dma_addr; the low DMA_AW bits of the current address.
- FIFO_DEPTH, 4: payload buffer depth; power of two, ≥2.
- FILE_INDEX, 8'h41: ioctl_index value that selects this loader.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  file type index.
- ioctl_wr  in  1  one-cycle strobe: ioctl_dout valid.
- ioctl_dout  in  8  file byte.
- dma_addr  out  DMA_AW  target address.
- dma_dout  out  8  target data.
- dma_we  out  1  write request; held until dma_ack.
- dma_ack  in  1  target accepts the current write this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of load.
- load_addr  out  ADDR_W  header address, latched.
- end_addr  out  ADDR_W  address one past the last byte written.
- err_overflow  out  1  sticky per load: a payload byte was dropped.
- err_short  out  1  sticky per load: download ended before the header completed.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; FIFO emptied; counters 0.
- A load starts only in IDLE, on a rising edge of ioctl_download with ioctl_index==FILE_INDEX. Other indices are ignored entirely.
- States:
  - IDLE -> HDR_LO on start; clear both errors, load_addr and end_addr.
  - HDR_LO: ioctl_wr latches load_addr[7:0] -> HDR_HI.
  - HDR_HI: ioctl_wr latches load_addr[15:8]; cur_addr<=header value -> DATA.
  - DATA: each ioctl_wr pushes the byte into the FIFO.
  - Download fall in HDR_LO/HDR_HI: set err_short -> DONE; no DMA writes occur.
  - Download fall in DATA -> DRAIN.
  - DRAIN -> DONE when the FIFO is empty (the last ack has completed).
  - DONE: done=1 for exactly one cycle -> IDLE.
- ioctl has no backpressure. A push when the FIFO is full and no pop happens this cycle drops the byte and sets err_overflow.
- Push and pop in the same cycle while full is legal; the byte is kept.
- DMA side uses show-ahead:
  - dma_we = FIFO non-empty; dma_dout = FIFO head; dma_addr = cur_addr[DMA_AW-1:0].
  - On dma_we&&dma_ack: pop, cur_addr+1, end_addr<=cur_addr+1.
  - Latency: a byte strobed at cycle n is presented no earlier than cycle n+1.
  - dma_addr/dma_dout must stay stable while dma_we=1 and dma_ack=0.
- cur_addr wraps modulo 2^ADDR_W; end_addr wraps likewise.
- end_addr equals load_addr at DONE if no payload was written.
- ioctl_wr in IDLE, DRAIN or DONE is ignored.
- A download rising edge outside IDLE is ignored (no restart).
- Reset mid-operation abandons the load; no done pulse.
- load_addr, end_addr and the error flags hold after DONE until the next start.

Decomposition:
- Shared package pet_loader_pkg: state enum (IDLE, HDR_LO, HDR_HI, DATA, DRAIN, DONE); constant PRG_HDR_BYTES=2.
- Sub-module byte_fifo:
  - Parameters DEPTH, WIDTH=8.
  - Ports: push, pop, din, dout (show-ahead), empty, full; async active-low reset.
  - Its count is (clog2(DEPTH)+1) bits wide.

Test Plan:
1. Index 8'h41; bytes 01 04 AA BB CC; dma_ack=1 -> writes AA@0x0401, BB@0x0402, CC@0x0403; done one pulse; load_addr=0x0401, end_addr=0x0404; no errors.
2. Same stream with ioctl_index=8'h01 -> dma_we never asserted, busy stays 0, no done.
3. DEPTH=4; dma_ack=0 until 10 cycles after the download falls; 3 payload bytes 11 22 33 -> addresses/data stable while stalled; written in order once ack=1; err_overflow=0; done only after the last ack.
4. DEPTH=4; dma_ack=0 throughout 6 payload bytes, then 1 -> first 4 bytes written; err_overflow=1; end_addr=load_addr+4.
5. Single byte 01, then download falls -> err_short=1, done pulses, zero DMA writes.
6. Header FF FF, payload 5A A5 -> dma_addr 0x3FFF then 0x0000; end_addr=0x0001.
7. Assert reset_n=0 mid-DATA -> all outputs 0 immediately; a subsequent clean load behaves as scenario 1.
